// File: rtl/clock_pkg.sv
// ============================================================================
// Module : clock_pkg
// Brief  : Shared state encodings, field limits and wrap helpers for the clock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    typedef logic [1:0] state_t;

    // State encoding doubles as the edit_field encoding.
    localparam state_t ST_RUN      = 2'd0;
    localparam state_t ST_SET_HOUR = 2'd1;
    localparam state_t ST_SET_MIN  = 2'd2;
    localparam state_t ST_SET_SEC  = 2'd3;

    localparam logic [1:0] EF_NONE   = 2'd0;
    localparam logic [1:0] EF_HOUR   = 2'd1;
    localparam logic [1:0] EF_MINUTE = 2'd2;
    localparam logic [1:0] EF_SECOND = 2'd3;

    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    function automatic logic [4:0] wrap_inc5(input logic [4:0] v, input logic [4:0] max);
        return (v == max) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] wrap_inc6(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_edge.sv
// ============================================================================
// Module : btn_edge
// Brief  : Two-flop synchronizer plus rising-edge detector for a push button.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Derived only from flops; a held button gives a single cycle pulse.
    assign o_press = r_sync2 & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/clock_set_ctrl.sv
// ============================================================================
// Module : clock_set_ctrl
// Brief  : One-second prescaler, HH:MM:SS counter and two-button set-mode FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 65536
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] edit_field,
    output logic       blink,
    output logic       second_tick
);

    localparam int                c_PW         = $clog2(TICK_DIV);
    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(TICK_DIV - 1);
    localparam logic [c_PW-1:0] c_PRESC_HALF = c_PW'(TICK_DIV / 2 - 1);

    logic [c_PW-1:0] r_presc;
    state_t          r_state;
    logic [4:0]      r_hour;
    logic [5:0]      r_min;
    logic [5:0]      r_sec;
    logic            r_phase;
    logic            r_blink;
    logic            r_tick;

    logic [c_PW-1:0] w_presc_nxt;
    state_t          w_state_nxt;
    logic [4:0]      w_hour_nxt;
    logic [5:0]      w_min_nxt;
    logic [5:0]      w_sec_nxt;
    logic            w_phase_nxt;
    logic            w_wrap;
    logic            w_half;
    logic            w_press_mode;
    logic            w_press_inc;

    btn_edge u_btn_mode (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_mode),
        .o_press (w_press_mode)
    );

    btn_edge u_btn_inc (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_inc),
        .o_press (w_press_inc)
    );

    assign w_wrap = (r_presc == c_PRESC_LAST);
    assign w_half = (r_presc == c_PRESC_HALF);

    always_comb begin
        w_presc_nxt = w_wrap ? '0 : r_presc + c_PW'(1);
        w_phase_nxt = r_phase ^ (w_wrap | w_half);
        w_state_nxt = r_state;
        w_hour_nxt  = r_hour;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;

        case (r_state)
            ST_RUN: begin
                if (w_wrap) begin
                    w_sec_nxt = wrap_inc6(r_sec, SEC_MAX);
                    if (r_sec == SEC_MAX) begin
                        w_min_nxt = wrap_inc6(r_min, MIN_MAX);
                        if (r_min == MIN_MAX) begin
                            w_hour_nxt = wrap_inc5(r_hour, HOUR_MAX);
                        end
                    end
                end
                if (w_press_mode) begin
                    w_state_nxt = ST_SET_HOUR;
                end
            end
            ST_SET_HOUR: begin
                if (w_press_mode) begin
                    w_state_nxt = ST_SET_MIN;
                end else if (w_press_inc) begin
                    w_hour_nxt = wrap_inc5(r_hour, HOUR_MAX);
                end
            end
            ST_SET_MIN: begin
                if (w_press_mode) begin
                    w_state_nxt = ST_SET_SEC;
                end else if (w_press_inc) begin
                    w_min_nxt = wrap_inc6(r_min, MIN_MAX);
                end
            end
            ST_SET_SEC: begin
                // Leaving set mode restarts the second so the first RUN tick is a full period away.
                if (w_press_mode) begin
                    w_state_nxt = ST_RUN;
                    w_presc_nxt = '0;
                    w_phase_nxt = 1'b0;
                end else if (w_press_inc) begin
                    w_sec_nxt = wrap_inc6(r_sec, SEC_MAX);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_presc <= '0;
            r_state <= ST_RUN;
            r_hour  <= 5'd0;
            r_min   <= 6'd0;
            r_sec   <= 6'd0;
            r_phase <= 1'b0;
            r_blink <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_state <= w_state_nxt;
            r_hour  <= w_hour_nxt;
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
            r_phase <= w_phase_nxt;
            r_blink <= w_phase_nxt & (w_state_nxt != ST_RUN);
            r_tick  <= w_wrap;
        end
    end

    assign hour        = r_hour;
    assign minute      = r_min;
    assign second      = r_sec;
    assign edit_field  = r_state;
    assign blink       = r_blink;
    assign second_tick = r_tick;

endmodule

`default_nettype wire

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Timekeeping and time-setting controller for the seven-segment clock. Divides `clock` into a one-second tick and keeps an HH:MM:SS count. A two-button set-mode state machine lets the user select and adjust each field. Outputs drive the digit-select/segment display path and supply a blink phase so the field being edited can be flashed.

## Interface
Parameters:
- `TICK_DIV`, default 65536: `clock` cycles per second tick. Must be even and ≥ 4.

Ports:
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  reset; synchronous, active-high. Single clock domain.
- `btn_mode`  in  1  asynchronous button; a rising edge advances the set-mode state.
- `btn_inc`  in  1  asynchronous button; a rising edge increments the field being edited.
- `hour`  out  5  hours, 0–23.
- `minute`  out  6  minutes, 0–59.
- `second`  out  6  seconds, 0–59.
- `edit_field`  out  2  field being edited: 0 none (RUN), 1 hour, 2 minute, 3 second.
- `blink`  out  1  blank phase for the edited field; always 0 in RUN.
- `second_tick`  out  1  one-cycle pulse per prescaler wrap, in all states.

## Operation
- Reset (`reset` high at a rising edge): every register and output goes to 0, the state goes to RUN, and the prescaler goes to 0.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 every cycle in every state, then wraps to 0.
  - The wrap event is W (prescaler == `TICK_DIV`-1).
- Button path:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detector.
  - Each press yields one `press_*` pulse one cycle long. A held button yields exactly one pulse.
- State machine: RUN → SET_HOUR → SET_MIN → SET_SEC → RUN. It advances on `press_mode` only.
  - `edit_field` = 0/1/2/3 respectively.
- RUN:
  - On W, `second` increments.
  - 59 wraps to 0 and carries into `minute`. `minute` 59 wraps and carries into `hour`. `hour` 23 wraps to 0 (23:59:59 → 00:00:00).
  - `press_inc` is ignored.
- SET_* states:
  - Time is frozen and W does not count.
  - `press_inc` increments only the edited field, with its own wrap (hour 23→0, minute/second 59→0). There is no carry into other fields.
- SET_SEC → RUN transition: the prescaler is cleared to 0, so the first increment in RUN comes a full `TICK_DIV` cycles after the transition edge.
- `blink`:
  - An internal phase bit toggles when prescaler == `TICK_DIV`/2-1 and on W.
  - `blink` = phase AND (state ≠ RUN).
  - The phase is cleared on the SET_SEC→RUN transition.
- Simultaneous events:
  - `press_mode` and `press_inc` in the same cycle: mode wins and inc is dropped.
  - W and `press_inc` in a SET state: the inc is applied and W is ignored for time.
  - W and `press_mode` in the same cycle while in RUN: the tick is applied and the state advances to SET_HOUR.
- `reset` mid-edit: time returns to 00:00:00 in RUN, and the synchronizer contents are discarded (cleared).

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Button latency:
  - An edge on `btn_*` sampled at rising edge k produces a field or state update visible after edge k+2.
  - The input must be high for ≥ 1 sampling edge to be seen.
- Tick:
  - At the edge where prescaler == `TICK_DIV`-1, `second` updates and `second_tick` goes high for exactly the following cycle.
  - After reset release, the first tick lands on the `TICK_DIV`-th edge.
- `blink` period is `TICK_DIV` cycles with a 50 % duty cycle.

## Structure
- Shared package `clock_pkg`:
  - State enum (RUN, SET_HOUR, SET_MIN, SET_SEC).
  - `edit_field` encodings.
  - Constants `HOUR_MAX`=23, `MIN_MAX`=59, `SEC_MAX`=59.
- One sub-module `btn_edge` (2-flop sync + edge detect, sync active-high reset), instantiated twice.
- The prescaler, state machine and time counters stay in the top module.

## Test plan
All scenarios run with `TICK_DIV`=4.
- Reset then run 16 cycles → `second`=4; `second_tick` pulsed 4 times, each 1 cycle long; `blink`=0 throughout.
- Preload 23:59:58 via set mode, return to RUN, run 8 cycles → 00:00:00 with one carry chain, no skipped values.
- One mode press, then 25 inc presses → `edit_field`=1; `hour`=1 (wrap 23→0); `minute`/`second` unchanged; time frozen across ≥ 3 W events.
- Mode and inc rise on the same edge in RUN → state SET_HOUR, no field change; button held 20 cycles → exactly one state step.
- Three mode presses to SET_SEC, a fourth back to RUN → `second` first increments exactly 4 edges after the transition edge; `blink` alternates 2 high/2 low while in SET states.
- Assert `reset` for 1 cycle while in SET_MIN with `minute`=37 → next cycle all outputs 0, `edit_field`=0; a `btn_inc` press in flight is discarded.
